sap_sequencer: RTL
==================

Name: sap_sequencer

Overview:
- Controller/Sequencer for the 8-bit SAP-style computer; occupies the CNTRL slot (sel = 4'b0111).
- Consumes the 4-bit opcode from the Instruction Register and produces the per-T-state control word that drives PC, MAR, Mem, IR, Acc, B register, ALU and Output Register.
- Replaces manual OE/WE/load driving for program execution.
- Contains a six-state ring counter, halt logic, single-step/run gating and a retired-instruction counter.

Parameters:
- SKIP_NOP, 0, 1 = instructions jump straight to T1 after their last useful T-state instead of idling through empty T-states.
- ICNT_W, 8, width of retired-instruction counter.

Ports:
- CLK  input  1  system clock, all state changes on rising edge
- RESET  input  1  asynchronous, active-high reset
- opcode  input  4  IR upper nibble; IR holds it stable T4–T6
- run  input  1  1 = advance each cycle; 0 = freeze state
- step  input  1  single-cycle pulse; advances one T-state while run=0
- pc_en  output  1  PC increment (Cp)
- pc_oe  output  1  PC drives bus (Ep)
- mar_we  output  1  MAR loads from bus (Lm)
- mem_oe  output  1  Mem drives bus (CE)
- ir_we  output  1  IR loads from bus (Li)
- ir_oe  output  1  IR operand nibble drives bus (Ei)
- acc_we  output  1  Acc loads from bus (La)
- acc_oe  output  1  Acc drives bus (Ea)
- breg_we  output  1  B register loads (Lb)
- alu_oe  output  1  ALU drives bus (Eu)
- sub  output  1  ALU subtract select (Su)
- or_we  output  1  Output Register loads (Lo)
- tstate  output  6  one-hot current T-state, bit0 = T1
- halted  output  1  HLT executed
- icount  output  ICNT_W  retired-instruction count

Behaviour:
- Reset (async, active-high): tstate = 6'b000001, halted = 0, icount = 0. All control outputs are 0 while RESET is high, overriding decode. Reset mid-instruction aborts it; no partial retire.
- Advance condition: adv = ~halted & (run | step). If adv = 0, tstate is held and every control output is forced to 0. On resume, execution continues at the held T-state with its normal word.
- Control outputs are Moore: combinational decode of registered tstate plus opcode. A word is valid for the whole cycle; the target register captures on the edge that ends the cycle.
- Fetch, all opcodes:
  - T1: pc_oe, mar_we.
  - T2: pc_en.
  - T3: mem_oe, ir_we.
- Execute:
  - LDA 4'h0: T4 ir_oe, mar_we; T5 mem_oe, acc_we; T6 none.
  - ADD 4'h1: T4 ir_oe, mar_we; T5 mem_oe, breg_we; T6 alu_oe, acc_we.
  - SUB 4'h2: as ADD, with sub=1 in T5 and T6.
  - OUT 4'hE: T4 acc_oe, or_we; T5, T6 none.
  - HLT 4'hF: T4 no strobes; halted set on the T4 edge; tstate stays T4; halted is sticky until RESET.
  - Any other opcode: NOP, T4–T6 empty.
- Transitions: T1→…→T6→T1. With SKIP_NOP=1:
  - LDA T5→T1.
  - OUT T4→T1.
  - NOP T4→T1.
- Retire: icount increments on the edge leaving the last T-state of an instruction. HLT does not retire. icount wraps from max to 0.
- Bus exclusivity: at most one of pc_oe, mem_oe, ir_oe, acc_oe, alu_oe is 1 in any cycle. This is a guaranteed invariant checked by assertion.
- Simultaneous run and step: treated as run. step while halted is ignored.

Decomposition:
- Shared package sap_pkg holds:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT;
  - a T-state one-hot localparam set;
  - a packed control-word struct ctrl_word_t with one field per strobe, consumed by the top level.
- One sub-module: sap_ring_counter. It is a 6-bit one-hot ring with advance, synchronous jump-to-T1 and hold inputs, asynchronous reset to T1.
- Decode stays in sap_sequencer.

Test Plan:
- Reset then run=1, opcode=4'h0 (LDA), SKIP_NOP=0: T1 pc_oe+mar_we, T2 pc_en, T3 mem_oe+ir_we, T4 ir_oe+mar_we, T5 mem_oe+acc_we, T6 empty. icount 0→1 after cycle 6; tstate back to 6'b000001.
- opcode=4'h2 (SUB): sub=1 only in T5 and T6. T6 shows alu_oe+acc_we. After 6 cycles icount=1.
- opcode=4'hE, SKIP_NOP=1: T4 acc_oe+or_we, then T1 on the next cycle (4-cycle instruction).
- opcode=4'hF: halted=1 after the T4 edge. tstate frozen at 6'b001000 and all strobes 0 for 20 cycles despite run=1 and step pulses. icount unchanged.
- run=0 at T3, then three step pulses separated by idle cycles: tstate goes T3→T4→T5→T6, exactly one advance per pulse, strobes 0 on idle cycles.
- RESET asserted mid-T5 of ADD: outputs 0 immediately without waiting for CLK, tstate=T1, icount=0. Separately, 256 NOPs with ICNT_W=8 → icount wraps to 0.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared opcode, T-state and control-word definitions for the SAP controller/sequencer.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef struct packed {
        logic pc_en;
        logic pc_oe;
        logic mar_we;
        logic mem_oe;
        logic ir_we;
        logic ir_oe;
        logic acc_we;
        logic acc_oe;
        logic breg_we;
        logic alu_oe;
        logic sub;
        logic or_we;
    } ctrl_word_t;

endpackage

// File: rtl/sap_ring_counter.sv
// Six-state one-hot T-state ring with advance, jump-to-T1 and hold.
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    input  logic       jump,
    input  logic       hold,
    output logic [5:0] state
);

    logic [5:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (adv && !hold) begin
            state_d = jump ? T1 : {state_q[4:0], state_q[5]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/sap_sequencer.sv
// SAP controller/sequencer: T-state sequencing, opcode decode to control word,
// halt, run/step gating and retired-instruction counting.
module sap_sequencer
    import sap_pkg::*;
#(
    parameter int unsigned SKIP_NOP = 0,
    parameter int unsigned ICNT_W   = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [3:0]        opcode,
    input  logic              run,
    input  logic              step,
    output logic              pc_en,
    output logic              pc_oe,
    output logic              mar_we,
    output logic              mem_oe,
    output logic              ir_we,
    output logic              ir_oe,
    output logic              acc_we,
    output logic              acc_oe,
    output logic              breg_we,
    output logic              alu_oe,
    output logic              sub,
    output logic              or_we,
    output logic [5:0]        tstate,
    output logic              halted,
    output logic [ICNT_W-1:0] icount
);

    logic              halted_q, halted_d;
    logic [ICNT_W-1:0] icount_q, icount_d;
    logic              adv, is_nop, last_t, hlt_hold;
    ctrl_word_t        cw;

    sap_ring_counter u_ring (
        .clk   (CLK),
        .rst   (RESET),
        .adv   (adv),
        .jump  (last_t),
        .hold  (hlt_hold),
        .state (tstate)
    );

    always_comb begin
        adv      = ~halted_q & (run | step);
        is_nop   = !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT});
        hlt_hold = (opcode == OP_HLT) && (tstate == T4);
        last_t   = (tstate == T6);
        // Early exit to T1 once the instruction has no further useful T-states
        if (SKIP_NOP != 0) begin
            if (opcode == OP_LDA && tstate == T5) last_t = 1'b1;
            if ((opcode == OP_OUT || is_nop) && tstate == T4) last_t = 1'b1;
        end
        halted_d = halted_q | (adv & hlt_hold);
        icount_d = icount_q;
        if (adv && last_t) icount_d = icount_q + ICNT_W'(1);
    end

    always_comb begin
        cw = '0;
        case (tstate)
            T1: begin cw.pc_oe = 1'b1; cw.mar_we = 1'b1; end
            T2: cw.pc_en = 1'b1;
            T3: begin cw.mem_oe = 1'b1; cw.ir_we = 1'b1; end
            T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin cw.ir_oe = 1'b1; cw.mar_we = 1'b1; end
                    OP_OUT: begin cw.acc_oe = 1'b1; cw.or_we = 1'b1; end
                    default: ;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_LDA: begin cw.mem_oe = 1'b1; cw.acc_we = 1'b1; end
                    OP_ADD, OP_SUB: begin
                        cw.mem_oe  = 1'b1;
                        cw.breg_we = 1'b1;
                        cw.sub     = (opcode == OP_SUB);
                    end
                    default: ;
                endcase
            end
            T6: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw.alu_oe = 1'b1;
                    cw.acc_we = 1'b1;
                    cw.sub    = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
        // Frozen or in reset: the whole word is suppressed, not just the edge effects
        if (!adv || RESET) cw = '0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            halted_q <= 1'b0;
            icount_q <= '0;
        end else begin
            halted_q <= halted_d;
            icount_q <= icount_d;
        end
    end

    assign pc_en   = cw.pc_en;
    assign pc_oe   = cw.pc_oe;
    assign mar_we  = cw.mar_we;
    assign mem_oe  = cw.mem_oe;
    assign ir_we   = cw.ir_we;
    assign ir_oe   = cw.ir_oe;
    assign acc_we  = cw.acc_we;
    assign acc_oe  = cw.acc_oe;
    assign breg_we = cw.breg_we;
    assign alu_oe  = cw.alu_oe;
    assign sub     = cw.sub;
    assign or_we   = cw.or_we;
    assign halted  = halted_q;
    assign icount  = icount_q;

    a_bus_excl: assert property (@(posedge CLK) disable iff (RESET)
        $onehot0({pc_oe, mem_oe, ir_oe, acc_oe, alu_oe}));

endmodule
